// File: rtl/psk_sweep_dispatcher_if.sv
// Correlator sign-bit input and sweep result bus of the PSK sweep dispatcher.
interface psk_sweep_dispatcher_if #(
    parameter int unsigned OFF_W = 5,
    parameter int unsigned CW_W  = 16
);
    logic             stb;
    logic             i_sign;
    logic             q_sign;
    logic             mode;
    logic [OFF_W-1:0] hold_offset;
    logic [CW_W-1:0]  control_word;
    logic [7:0]       value;
    logic [OFF_W-1:0] value_offset;
    logic             rdy;
    logic [7:0]       best_value;
    logic [OFF_W-1:0] best_offset;
    logic             sweep_done;
    logic             stb_overrun;

    // Sample source / result consumer side
    modport master (
        output stb, i_sign, q_sign, mode, hold_offset,
        input  control_word, value, value_offset, rdy,
               best_value, best_offset, sweep_done, stb_overrun
    );

    // Dispatcher side
    modport slave (
        input  stb, i_sign, q_sign, mode, hold_offset,
        output control_word, value, value_offset, rdy,
               best_value, best_offset, sweep_done, stb_overrun
    );
endinterface

// File: rtl/psk_sweep_dispatcher.sv
// PSK sweep dispatcher: measures average alternating I/Q sign run length per window,
// steps the NCO offset per window and tracks the best offset across a sweep.
module psk_sweep_dispatcher #(
    parameter int unsigned    CNT_W    = 8,
    parameter int unsigned    WIN_LOG2 = 12,
    parameter int unsigned    OFF_W    = 5,
    parameter int unsigned    CW_W     = 16,
    parameter logic [CW_W-1:0] BASE_CW = 16'h0ff0
) (
    input  logic                  clk,
    input  logic                  rst_in_n,
    psk_sweep_dispatcher_if.slave bus
);
    localparam int unsigned SUM_W = CNT_W + WIN_LOG2;

    typedef enum logic {PH_I = 1'b0, PH_Q = 1'b1} phase_t;

    logic               pend;
    logic               pend_i;
    logic               pend_q;
    logic               prime;
    logic               prev_i;
    logic               prev_q;
    phase_t             phase;
    logic [CNT_W-1:0]   cnt_i;
    logic [CNT_W-1:0]   cnt_q;
    logic [SUM_W-1:0]   sum;
    logic [WIN_LOG2-1:0] tcount;
    logic [OFF_W-1:0]   offset;
    logic               run_valid;
    logic [7:0]         run_best;
    logic [OFF_W-1:0]   run_best_off;

    logic               tr_i;
    logic               tr_q;
    logic               accept;
    logic               close;
    logic [CNT_W-1:0]   acc_len;
    logic [SUM_W-1:0]   sum_total;
    logic [SUM_W-1:0]   avg;
    logic [7:0]         win_value;
    logic [OFF_W-1:0]   next_off;
    logic               take_peak;
    logic [7:0]         peak_val;
    logic [OFF_W-1:0]   peak_off;
    logic               wrap;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == '1) ? c : c + CNT_W'(1);
    endfunction

    // Transition detection, acceptance, window average and peak candidate
    always_comb begin
        tr_i      = pend_i != prev_i;
        tr_q      = pend_q != prev_q;
        accept    = pend && !prime && ((phase == PH_Q) ? tr_q : tr_i);
        close     = accept && (tcount == '1);
        acc_len   = (phase == PH_Q) ? cnt_q : cnt_i;
        sum_total = sum + SUM_W'(acc_len);
        avg       = sum_total >> WIN_LOG2;
        win_value = (|(avg >> 8)) ? 8'hff : 8'(avg);
        next_off  = bus.mode ? bus.hold_offset : offset + OFF_W'(1);
        take_peak = !run_valid || (win_value > run_best);
        peak_val  = take_peak ? win_value : run_best;
        peak_off  = take_peak ? offset : run_best_off;
        wrap      = !bus.mode && (offset == '1);
    end

    // Sample capture, run-length processing, window close and sweep bookkeeping
    always_ff @(posedge clk or negedge rst_in_n) begin
        if (!rst_in_n) begin
            pend             <= 1'b0;
            pend_i           <= 1'b0;
            pend_q           <= 1'b0;
            prime            <= 1'b1;
            prev_i           <= 1'b0;
            prev_q           <= 1'b0;
            phase            <= PH_I;
            cnt_i            <= '0;
            cnt_q            <= '0;
            sum              <= '0;
            tcount           <= '0;
            offset           <= '0;
            run_valid        <= 1'b0;
            run_best         <= '0;
            run_best_off     <= '0;
            bus.control_word <= BASE_CW;
            bus.value        <= '0;
            bus.value_offset <= '0;
            bus.rdy          <= 1'b0;
            bus.best_value   <= '0;
            bus.best_offset  <= '0;
            bus.sweep_done   <= 1'b0;
            bus.stb_overrun  <= 1'b0;
        end else begin
            bus.rdy        <= 1'b0;
            bus.sweep_done <= 1'b0;
            if (pend) begin
                pend <= 1'b0;
                if (bus.stb) begin
                    bus.stb_overrun <= 1'b1;
                end
                if (prime) begin
                    prev_i <= pend_i;
                    prev_q <= pend_q;
                    cnt_i  <= CNT_W'(1);
                    cnt_q  <= CNT_W'(1);
                    phase  <= PH_I;
                    prime  <= 1'b0;
                end else begin
                    cnt_i  <= tr_i ? CNT_W'(1) : sat_inc(cnt_i);
                    cnt_q  <= tr_q ? CNT_W'(1) : sat_inc(cnt_q);
                    prev_i <= pend_i;
                    prev_q <= pend_q;
                    if (accept) begin
                        phase  <= (phase == PH_Q) ? PH_I : PH_Q;
                        tcount <= tcount + WIN_LOG2'(1);
                        sum    <= sum_total;
                        if (close) begin
                            sum              <= '0;
                            prime            <= 1'b1;
                            bus.value        <= win_value;
                            bus.value_offset <= offset;
                            bus.rdy          <= 1'b1;
                            offset           <= next_off;
                            bus.control_word <= BASE_CW + CW_W'(next_off);
                            if (bus.mode) begin
                                run_valid    <= 1'b0;
                                run_best     <= '0;
                                run_best_off <= '0;
                            end else if (wrap) begin
                                bus.best_value  <= peak_val;
                                bus.best_offset <= peak_off;
                                bus.sweep_done  <= 1'b1;
                                run_valid       <= 1'b0;
                                run_best        <= '0;
                                run_best_off    <= '0;
                            end else begin
                                run_valid    <= 1'b1;
                                run_best     <= peak_val;
                                run_best_off <= peak_off;
                            end
                        end
                    end
                end
            end else if (bus.stb) begin
                pend   <= 1'b1;
                pend_i <= bus.i_sign;
                pend_q <= bus.q_sign;
            end
        end
    end
endmodule

// File: tb/tb_psk_sweep_dispatcher.sv
// Directed bench for psk_sweep_dispatcher with WIN_LOG2=2, OFF_W=2.
module tb_psk_sweep_dispatcher;
    logic clk;
    logic rst_in_n;
    int   total;
    int   bad;

    // Observations collected while stepping
    int        n_rdy;
    int        n_sd;
    logic [7:0] last_value;
    logic [1:0] last_off;
    logic       last_sd;
    logic       cur_i;
    logic       cur_q;

    psk_sweep_dispatcher_if #(.OFF_W(2), .CW_W(16)) bus ();

    psk_sweep_dispatcher #(
        .CNT_W(8), .WIN_LOG2(2), .OFF_W(2), .CW_W(16), .BASE_CW(16'h0ff0)
    ) dut (
        .clk(clk),
        .rst_in_n(rst_in_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic s, input logic i, input logic q);
        bus.stb    = s;
        bus.i_sign = i;
        bus.q_sign = q;
        @(posedge clk);
        #1;
        if (bus.rdy === 1'b1) begin
            n_rdy++;
            last_value = bus.value;
            last_off   = bus.value_offset;
            last_sd    = bus.sweep_done;
        end
        if (bus.sweep_done === 1'b1) n_sd++;
    endtask

    task automatic sample(input logic i, input logic q);
        step(1'b1, i, q);
        step(1'b0, i, q);
    endtask

    // Prime sample, then four accepted runs of the given lengths (both signs toggle per run end)
    task automatic run_window(input int l0, input int l1, input int l2, input int l3);
        int lens[4];
        lens = '{l0, l1, l2, l3};
        n_rdy = 0;
        sample(cur_i, cur_q);
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < lens[k] - 1; j++) sample(cur_i, cur_q);
            cur_i = ~cur_i;
            cur_q = ~cur_q;
            sample(cur_i, cur_q);
        end
    endtask

    task automatic do_reset();
        rst_in_n        = 1'b0;
        bus.stb         = 1'b0;
        bus.i_sign      = 1'b0;
        bus.q_sign      = 1'b0;
        bus.mode        = 1'b0;
        bus.hold_offset = 2'd0;
        cur_i = 1'b0;
        cur_q = 1'b0;
        n_rdy = 0;
        n_sd  = 0;
        repeat (2) @(posedge clk);
        #1 rst_in_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (bus.control_word !== 16'h0ff0) begin bad++; $display("FAIL reset_cw got=%h want=0ff0", bus.control_word); end
        total++; if ({bus.value, bus.value_offset, bus.rdy, bus.best_value, bus.best_offset, bus.sweep_done, bus.stb_overrun} !== '0)
            begin bad++; $display("FAIL reset_outputs got value=%0d rdy=%b ovr=%b want zeros", bus.value, bus.rdy, bus.stb_overrun); end
    endtask

    task automatic test_basic();
        do_reset();
        for (int k = 0; k <= 10; k++) sample(1'((k / 4) % 2), 1'(((k + 2) / 4) % 2));
        total++; if (n_rdy !== 1) begin bad++; $display("FAIL basic_rdy_count got=%0d want=1", n_rdy); end
        total++; if (last_value !== 8'd4) begin bad++; $display("FAIL basic_value got=%0d want=4", last_value); end
        total++; if (last_off !== 2'd0) begin bad++; $display("FAIL basic_offset got=%0d want=0", last_off); end
        total++; if (bus.control_word !== 16'h0ff1) begin bad++; $display("FAIL basic_cw got=%h want=0ff1", bus.control_word); end
    endtask

    task automatic test_saturation();
        do_reset();
        run_window(300, 1, 1, 1);
        total++; if (n_rdy !== 1 || last_value !== 8'd64) begin bad++; $display("FAIL sat_value got=%0d rdy=%0d want=64 rdy=1", last_value, n_rdy); end
    endtask

    task automatic test_sweep();
        int         vals[4];
        logic [7:0] exp_v[4];
        vals  = '{2, 6, 6, 3};
        exp_v = '{8'd2, 8'd6, 8'd6, 8'd3};
        do_reset();
        for (int w = 0; w < 4; w++) begin
            run_window(vals[w], vals[w], vals[w], vals[w]);
            total++; if (n_rdy !== 1 || last_value !== exp_v[w] || last_off !== 2'(w))
                begin bad++; $display("FAIL sweep_win%0d got v=%0d off=%0d rdy=%0d want v=%0d off=%0d", w, last_value, last_off, n_rdy, exp_v[w], w); end
            if (w == 2) begin
                total++; if (n_sd !== 0 || bus.best_value !== 8'd0) begin bad++; $display("FAIL sweep_early got sd=%0d best=%0d want 0 0", n_sd, bus.best_value); end
            end
        end
        total++; if (last_sd !== 1'b1 || n_sd !== 1) begin bad++; $display("FAIL sweep_done got=%b n=%0d want 1", last_sd, n_sd); end
        total++; if (bus.best_value !== 8'd6 || bus.best_offset !== 2'd1) begin bad++; $display("FAIL sweep_best got=%0d@%0d want=6@1", bus.best_value, bus.best_offset); end
        total++; if (bus.control_word !== 16'h0ff0) begin bad++; $display("FAIL sweep_cw got=%h want=0ff0", bus.control_word); end
    endtask

    task automatic test_lock();
        do_reset();
        bus.mode        = 1'b1;
        bus.hold_offset = 2'd3;
        for (int w = 0; w < 5; w++) begin
            run_window(2, 2, 2, 2);
            total++; if (n_rdy !== 1 || last_off !== ((w == 0) ? 2'd0 : 2'd3))
                begin bad++; $display("FAIL lock_win%0d got off=%0d rdy=%0d want off=%0d", w, last_off, n_rdy, (w == 0) ? 0 : 3); end
        end
        total++; if (bus.control_word !== 16'h0ff3) begin bad++; $display("FAIL lock_cw got=%h want=0ff3", bus.control_word); end
        total++; if (n_sd !== 0) begin bad++; $display("FAIL lock_sweep_done got=%0d want=0", n_sd); end
        bus.mode = 1'b0;
        run_window(5, 5, 5, 5);
        total++; if (last_off !== 2'd3 || last_value !== 8'd5 || last_sd !== 1'b1)
            begin bad++; $display("FAIL unlock_win got off=%0d v=%0d sd=%b want 3 5 1", last_off, last_value, last_sd); end
        total++; if (bus.best_value !== 8'd5 || bus.best_offset !== 2'd3 || bus.control_word !== 16'h0ff0)
            begin bad++; $display("FAIL unlock_best got=%0d@%0d cw=%h want=5@3 cw=0ff0", bus.best_value, bus.best_offset, bus.control_word); end
    endtask

    task automatic test_overrun();
        do_reset();
        n_rdy = 0;
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        total++; if (bus.stb_overrun !== 1'b1) begin bad++; $display("FAIL overrun_set got=%b want=1", bus.stb_overrun); end
        for (int k = 0; k < 4; k++) begin
            sample(cur_i, cur_q);
            cur_i = ~cur_i;
            cur_q = ~cur_q;
            sample(cur_i, cur_q);
        end
        total++; if (n_rdy !== 1 || last_value !== 8'd2) begin bad++; $display("FAIL overrun_drop got v=%0d rdy=%0d want v=2 rdy=1", last_value, n_rdy); end
        total++; if (bus.stb_overrun !== 1'b1) begin bad++; $display("FAIL overrun_sticky got=%b want=1", bus.stb_overrun); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        run_window(2, 2, 2, 2);
        n_rdy = 0;
        sample(cur_i, cur_q);
        for (int k = 0; k < 2; k++) begin
            sample(cur_i, cur_q);
            cur_i = ~cur_i;
            cur_q = ~cur_q;
            sample(cur_i, cur_q);
        end
        #2 rst_in_n = 1'b0;
        #1;
        total++; if (bus.value !== 8'd0 || bus.control_word !== 16'h0ff0 || bus.value_offset !== 2'd0)
            begin bad++; $display("FAIL midrst_outputs got v=%0d cw=%h want 0 0ff0", bus.value, bus.control_word); end
        @(posedge clk);
        #1 rst_in_n = 1'b1;
        run_window(3, 3, 3, 3);
        total++; if (n_rdy !== 1 || last_value !== 8'd3 || last_off !== 2'd0)
            begin bad++; $display("FAIL midrst_window got v=%0d off=%0d rdy=%0d want 3 0 1", last_value, last_off, n_rdy); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_basic();
        test_saturation();
        test_sweep();
        test_lock();
        test_overrun();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
